uart_hex_line_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_byte.sv | 93 +++++++++
 rtl/uart_hex_line_rx.sv | 79 +++++++
 tb/tb_uart_hex_line_rx.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART/ASCII helpers: receiver state encoding and the hex-digit decode.
package uart_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

   // True for '0'-'9', 'A'-'F', 'a'-'f'
   function automatic logic is_hex(input logic [7:0] b);
      return (b >= 8'h30 && b <= 8'h39) ||
             (b >= 8'h41 && b <= 8'h46) ||
             (b >= 8'h61 && b <= 8'h66);
   endfunction

   // Inverse of the nibble-to-ASCII mapping used on the LCD rows
   function automatic logic [3:0] hex2nib(input logic [7:0] b);
      logic [7:0] t;
      if (b <= 8'h39)      t = b - 8'h30;
      else if (b <= 8'h46) t = b - 8'h37;
      else                 t = b - 8'h57;
      return t[3:0];
   endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-FF input sync, baud counter, IDLE/START/DATA/STOP FSM.
import uart_pkg::*;

module uart_rx_byte #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk_50MHz,
   input  logic       reset_n,
   input  logic       uart_rx,
   output logic [7:0] data,
   output logic       byte_stb,
   output logic       fe_stb,
   output logic       busy
);

   localparam int HALF = CLKS_PER_BIT / 2;
   localparam int CW   = $clog2(CLKS_PER_BIT);

   logic            rx_meta, rx_s, rx_d;
   logic [CW-1:0]   baud_cnt;
   logic [2:0]      bit_idx;
   rx_state_t       state;
   logic            tick_half, tick_full;

   // Synchronize the async line; rx_d is one more stage kept for edge detection
   always_ff @(posedge clk_50MHz) begin
      if (!reset_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_d    <= 1'b1;
      end else begin
         rx_meta <= uart_rx;
         rx_s    <= rx_meta;
         rx_d    <= rx_s;
      end
   end

   assign tick_half = (baud_cnt == CW'(HALF - 1));
   assign tick_full = (baud_cnt == CW'(CLKS_PER_BIT - 1));

   // Stop-bit strobes are decoded from the sample cycle itself so the parser
   // can register its result on that same edge (one-cycle total latency).
   assign byte_stb = (state == STOP) && tick_full &&  rx_s;
   assign fe_stb   = (state == STOP) && tick_full && !rx_s;
   assign busy     = (state != IDLE);

   // Receiver FSM: start-edge detect, mid-bit sampling, LSB-first shift
   always_ff @(posedge clk_50MHz) begin
      if (!reset_n) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         data     <= '0;
      end else begin
         case (state)
            IDLE: begin
               baud_cnt <= '0;
               bit_idx  <= '0;
               if (rx_d && !rx_s) state <= START;
            end
            START: begin
               if (tick_half) begin
                  baud_cnt <= '0;
                  state    <= rx_s ? IDLE : DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            DATA: begin
               if (tick_full) begin
                  baud_cnt <= '0;
                  data     <= {rx_s, data[7:1]};
                  bit_idx  <= bit_idx + 1'b1;
                  if (bit_idx == 3'd7) state <= STOP;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            STOP: begin
               // Return right at the stop sample so the next start edge is caught
               if (tick_full) begin
                  baud_cnt <= '0;
                  state    <= IDLE;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_hex_line_rx.sv
// Hex-line receiver: CR/LF-terminated ASCII hex lines become a DIGITS-nibble value.
import uart_pkg::*;

module uart_hex_line_rx #(
   parameter int CLK_HZ = 50000000,
   parameter int BAUD   = 115200,
   parameter int DIGITS = 4
) (
   input  logic                clk_50MHz,
   input  logic                reset_n,
   input  logic                uart_rx,
   output logic [4*DIGITS-1:0] value,
   output logic                valid,
   output logic                err,
   output logic                busy
);

   localparam int CLKS_PER_BIT = (CLK_HZ + BAUD / 2) / BAUD;
   localparam int W            = 4 * DIGITS;
   localparam int CNTW         = $clog2(DIGITS + 1);
   localparam logic [CNTW-1:0] DIG_MAX = CNTW'(DIGITS);

   logic [7:0]      rx_data;
   logic            byte_stb, fe_stb;
   logic [W-1:0]    acc;
   logic [CNTW-1:0] cnt;
   logic            bad;

   uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk_50MHz (clk_50MHz),
      .reset_n   (reset_n),
      .uart_rx   (uart_rx),
      .data      (rx_data),
      .byte_stb  (byte_stb),
      .fe_stb    (fe_stb),
      .busy      (busy)
   );

   // Line parser: accumulate digits, publish or reject on CR/LF
   always_ff @(posedge clk_50MHz) begin
      if (!reset_n) begin
         acc   <= '0;
         cnt   <= '0;
         bad   <= 1'b0;
         value <= '0;
         valid <= 1'b0;
         err   <= 1'b0;
      end else begin
         valid <= 1'b0;
         err   <= 1'b0;
         if (byte_stb) begin
            if (is_hex(rx_data)) begin
               if (cnt < DIG_MAX) begin
                  acc <= W'({acc, hex2nib(rx_data)});
                  cnt <= cnt + 1'b1;
               end else begin
                  bad <= 1'b1;
               end
            end else if (rx_data == ASCII_CR || rx_data == ASCII_LF) begin
               // Empty clean lines (e.g. the LF of CRLF) stay silent
               if (bad) begin
                  err <= 1'b1;
               end else if (cnt != '0) begin
                  value <= acc;
                  valid <= 1'b1;
               end
               acc <= '0;
               cnt <= '0;
               bad <= 1'b0;
            end else begin
               bad <= 1'b1;
            end
         end else if (fe_stb) begin
            bad <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_hex_line_rx.sv
// Directed bench for uart_hex_line_rx; a faster baud keeps the run short while
// the half-bit window (108 cycles) still exceeds the 100-cycle glitch.
module tb_uart_hex_line_rx;

   localparam int CLK_HZ = 50000000;
   localparam int BAUD   = 230400;
   localparam int CPB    = (CLK_HZ + BAUD / 2) / BAUD;  // 217

   logic        clk_50MHz = 1'b0;
   logic        reset_n   = 1'b0;
   logic        uart_rx   = 1'b1;
   logic [15:0] value;
   logic        valid, err, busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int nval  = 0;
   int nerr  = 0;
   int last_v_cyc = 0;
   int stop_cyc   = 0;
   int v0, e0;

   uart_hex_line_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DIGITS(4)) dut (
      .clk_50MHz (clk_50MHz),
      .reset_n   (reset_n),
      .uart_rx   (uart_rx),
      .value     (value),
      .valid     (valid),
      .err       (err),
      .busy      (busy)
   );

   always #10 clk_50MHz = ~clk_50MHz;

   always @(posedge clk_50MHz) cyc <= cyc + 1;

   // Pulse monitor: a pulse held two cycles counts twice
   always @(negedge clk_50MHz) begin
      if (valid) begin
         nval       <= nval + 1;
         last_v_cyc <= cyc;
      end
      if (err) nerr <= nerr + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic bit_time(input logic b);
      uart_rx = b;
      repeat (CPB) @(negedge clk_50MHz);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      bit_time(1'b0);
      for (int i = 0; i < 8; i++) bit_time(b[i]);
      stop_cyc = cyc;
      bit_time(stop);
      bit_time(1'b1);
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
   endtask

   task automatic mark();
      repeat (4) @(negedge clk_50MHz);
      v0 = nval;
      e0 = nerr;
   endtask

   initial begin
      // Reset state
      repeat (5) @(negedge clk_50MHz);
      chk("rst_value", value, 16'h0000);
      chk("rst_valid", valid, 1'b0);
      chk("rst_err",   err,   1'b0);
      chk("rst_busy",  busy,  1'b0);
      reset_n = 1'b1;
      repeat (20) @(negedge clk_50MHz);

      // "1A2B" CR
      mark();
      send_str("1A2B");
      send_byte(8'h0D, 1'b1);
      chk("l1_nvalid", nval - v0, 1);
      chk("l1_nerr",   nerr - e0, 0);
      chk("l1_value",  value, 16'h1A2B);
      chk("l1_lat_win", (last_v_cyc > stop_cyc) && (last_v_cyc < stop_cyc + CPB), 1'b1);

      // "ff" CR LF: LF is a silent blank line
      mark();
      send_str("ff");
      send_byte(8'h0D, 1'b1);
      send_byte(8'h0A, 1'b1);
      chk("l2_nvalid", nval - v0, 1);
      chk("l2_nerr",   nerr - e0, 0);
      chk("l2_value",  value, 16'h00FF);

      // Overflow "12345" CR
      mark();
      send_str("12345");
      send_byte(8'h0D, 1'b1);
      chk("ovf_nerr",   nerr - e0, 1);
      chk("ovf_nvalid", nval - v0, 0);
      chk("ovf_value",  value, 16'h00FF);

      // Bad char, then a clean line proves bad was cleared
      mark();
      send_str("12G4");
      send_byte(8'h0A, 1'b1);
      chk("badch_nerr",   nerr - e0, 1);
      chk("badch_nvalid", nval - v0, 0);
      mark();
      send_str("7");
      send_byte(8'h0A, 1'b1);
      chk("l7_nvalid", nval - v0, 1);
      chk("l7_value",  value, 16'h0007);

      // Framing error on "3", then "4" CR is rejected
      mark();
      send_byte("3", 1'b0);
      send_str("4");
      send_byte(8'h0D, 1'b1);
      chk("fe_nerr",   nerr - e0, 1);
      chk("fe_nvalid", nval - v0, 0);
      chk("fe_value",  value, 16'h0007);
      mark();
      send_str("4");
      send_byte(8'h0D, 1'b1);
      chk("l4_nvalid", nval - v0, 1);
      chk("l4_value",  value, 16'h0004);

      // 100-cycle glitch: false start, no strobe
      mark();
      uart_rx = 1'b0;
      repeat (50) @(negedge clk_50MHz);
      chk("gl_busy_mid", busy, 1'b1);
      repeat (50) @(negedge clk_50MHz);
      uart_rx = 1'b1;
      repeat (CPB) @(negedge clk_50MHz);
      chk("gl_busy_end", busy, 1'b0);
      chk("gl_nvalid", nval - v0, 0);
      chk("gl_nerr",   nerr - e0, 0);

      // Break: one framing error, next terminator reports it
      mark();
      repeat (12) bit_time(1'b0);
      uart_rx = 1'b1;
      repeat (2 * CPB) @(negedge clk_50MHz);
      chk("brk_busy", busy, 1'b0);
      send_byte(8'h0D, 1'b1);
      chk("brk_nerr",   nerr - e0, 1);
      chk("brk_nvalid", nval - v0, 0);

      // Reset in the middle of '5'
      bit_time(1'b0);
      bit_time(1'b1);
      bit_time(1'b0);
      repeat (CPB / 2) @(negedge clk_50MHz);
      chk("mid_busy_pre", busy, 1'b1);
      reset_n = 1'b0;
      @(posedge clk_50MHz);
      #1;
      chk("mid_rst_value", value, 16'h0000);
      chk("mid_rst_busy",  busy,  1'b0);
      uart_rx = 1'b1;
      repeat (3) @(negedge clk_50MHz);
      reset_n = 1'b1;
      repeat (2 * CPB) @(negedge clk_50MHz);
      mark();
      send_str("9");
      send_byte(8'h0D, 1'b1);
      chk("post_nvalid", nval - v0, 1);
      chk("post_value",  value, 16'h0009);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
